// File: rtl/addsub_pkg.sv
// Shared types for the sequential add/subtract unit.
//   op_t    : operation encoding presented on the op port
//   state_t : control FSM states
package addsub_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBB = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/addsub_seq_cla_chunk.sv
// Combinational CHUNK-bit carry-lookahead adder.
//   a, b   : chunk operands
//   cin    : carry into bit 0
//   s      : chunk sum
//   cout   : carry out of the chunk MSB
//   c_msb  : carry into the chunk MSB (feeds the overflow flag on the top chunk)
module cla_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK-1:0] g;
  logic [CHUNK-1:0] p;
  logic [CHUNK:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Flattened lookahead term for the carry into bit n:
  //   cin & p[0..n-1]  |  OR_j ( g[j] & p[j+1..n-1] )
  function automatic logic carry_into(input logic [CHUNK-1:0] gv,
                                      input logic [CHUNK-1:0] pv,
                                      input logic             c0,
                                      input int               n);
    logic res;
    logic prod;
    res = c0;
    for (int j = 0; j < CHUNK; j++) begin
      if (j < n) res = res & pv[j];
    end
    for (int j = 0; j < CHUNK; j++) begin
      if (j < n) begin
        prod = gv[j];
        for (int k = 0; k < CHUNK; k++) begin
          if (k > j && k < n) prod = prod & pv[k];
        end
        res = res | prod;
      end
    end
    return res;
  endfunction

  assign c[0] = cin;

  genvar gi;
  generate
    for (gi = 0; gi < CHUNK; gi++) begin : g_carry
      assign c[gi+1] = carry_into(g, p, cin, gi + 1);
    end
  endgenerate

  assign s     = p ^ c[CHUNK-1:0];
  assign cout  = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle WIDTH-bit add/subtract, CHUNK bits per cycle, with carry
// chaining across ops (ADC/SBB) and valid/ready handshakes.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid/in_ready    : request handshake (op, a, b)
//   out_valid/out_ready  : result handshake (sum, cout, ovf, zero)
module addsub_seq
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  k_q, k_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;       // already inverted for SUB/SBB
  logic              carry_q, carry_d; // running inter-chunk carry
  logic [WIDTH-1:0]  acc_q, acc_d;   // private accumulator, never visible on sum
  logic              flag_q, flag_d; // stored carry for ADC/SBB
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;

  logic [CHUNK-1:0]  cla_s;
  logic              cla_cout;
  logic              cla_cmsb;

  cla_chunk #(.CHUNK(CHUNK)) u_cla (
    .a     (a_q[k_q*CHUNK +: CHUNK]),
    .b     (b_q[k_q*CHUNK +: CHUNK]),
    .cin   (carry_q),
    .s     (cla_s),
    .cout  (cla_cout),
    .c_msb (cla_cmsb)
  );

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    acc_d       = acc_q;
    flag_d      = flag_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          // The op only matters at capture: it selects B' and the carry-in.
          a_d   = a;
          acc_d = '0;
          k_d   = '0;
          case (op_t'(op))
            OP_ADD:  begin b_d = b;  carry_d = 1'b0;   end
            OP_SUB:  begin b_d = ~b; carry_d = 1'b1;   end
            OP_ADC:  begin b_d = b;  carry_d = flag_q; end
            default: begin b_d = ~b; carry_d = flag_q; end
          endcase
          state_d    = S_BUSY;
          in_ready_d = 1'b0;
        end
      end

      S_BUSY: begin
        acc_d[k_q*CHUNK +: CHUNK] = cla_s;
        carry_d = cla_cout;
        k_d     = k_q + 1'b1;
        if (k_q == CNT_W'(NCHUNK - 1)) begin
          k_d         = '0;
          state_d     = S_DONE;
          sum_d       = acc_d;
          cout_d      = cla_cout;
          ovf_d       = cla_cmsb ^ cla_cout;
          zero_d      = (acc_d == '0);
          flag_d      = cla_cout;
          out_valid_d = 1'b1;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      acc_q       <= '0;
      flag_q      <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      acc_q       <= acc_d;
      flag_q      <= flag_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_addsub_seq.sv
module tb_addsub_seq;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  int tests = 0;
  int fails = 0;

  addsub_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one op with out_ready held high and check result, flags and timing.
  task automatic do_op(input string tag, input logic [1:0] o,
                       input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                       input logic [WIDTH-1:0] es, input logic ec,
                       input logic eo, input logic ez);
    int cnt;
    @(negedge clk);
    check({tag, ".in_ready_idle"}, in_ready, 1'b1);
    in_valid = 1'b1;
    op = o;
    a  = va;
    b  = vb;
    @(posedge clk); #1;             // accept edge
    in_valid = 1'b0;
    a  = ~va;                       // later operand changes must be ignored
    b  = va ^ vb;
    op = ~o;
    check({tag, ".in_ready_busy"}, in_ready, 1'b0);
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    // out_valid appears NCHUNK edges after the accept edge (the fifth
    // cycle counting the accept cycle itself for NCHUNK=4).
    check({tag, ".latency"}, cnt, NCHUNK);
    check({tag, ".sum"},  sum,  es);
    check({tag, ".cout"}, cout, ec);
    check({tag, ".ovf"},  ovf,  eo);
    check({tag, ".zero"}, zero, ez);
    $display("[TB] %s op=%0d a=0x%08h b=0x%08h -> sum=0x%08h c=%0b v=%0b z=%0b",
             tag, o, va, vb, sum, cout, ovf, zero);
    @(posedge clk); #1;             // out_ready high: back to IDLE
    check({tag, ".out_valid_drop"}, out_valid, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op        = 2'b00;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("reset.out_valid", out_valid, 1'b0);
    check("reset.in_ready",  in_ready,  1'b1);
    check("reset.sum",       sum,       32'h0);
    check("reset.cout",      cout,      1'b0);
    check("reset.ovf",       ovf,       1'b0);
    check("reset.zero",      zero,      1'b0);
    $display("[TB] reset released");
    rst_n = 1'b1;

    // 1. wrap-around to zero
    do_op("add_wrap", 2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    // 2. signed overflow on subtract, no borrow
    do_op("sub_ovf",  2'b01, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    // 3. borrow then SBB uses the borrow: 0 + ~0 + 0
    do_op("sub_borrow", 2'b01, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    do_op("sbb_chain",  2'b11, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    // 4. 64-bit add in two ops: low word carries into high word
    do_op("add_lo", 2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    do_op("adc_hi", 2'b10, 32'h0000_0001, 32'h0000_0002, 32'h0000_0004, 1'b0, 1'b0, 1'b0);
    // positive overflow on ADD
    do_op("add_ovf", 2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0);

    // 5. backpressure: result held while out_ready low, new requests ignored
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; op = 2'b00; a = 32'h1234_5678; b = 32'h1111_1111;
    @(posedge clk); #1;
    in_valid = 1'b0;
    begin
      int cnt;
      cnt = 0;
      while (!out_valid && cnt < 20) begin
        @(posedge clk); #1;
        cnt++;
      end
      check("bp.latency", cnt, NCHUNK);
    end
    check("bp.sum", sum, 32'h2345_6789);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; op = 2'b01; a = 32'hA5A5_0000 + i; b = 32'h0000_1000 * i;
      @(posedge clk); #1;
      check("bp.out_valid_hold", out_valid, 1'b1);
      check("bp.sum_hold",       sum,       32'h2345_6789);
      check("bp.flags_hold",     {cout, ovf, zero}, 3'b000);
      check("bp.in_ready_low",   in_ready,  1'b0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp.release_valid", out_valid, 1'b0);
    check("bp.release_ready", in_ready,  1'b1);
    $display("[TB] backpressure sum=0x%08h released", sum);
    // sets the stored carry to 1 ahead of the reset test
    do_op("bp_next", 2'b00, 32'hFFFF_FFFF, 32'h0000_0003, 32'h0000_0002, 1'b1, 1'b0, 1'b0);

    // 6. reset during BUSY chunk 2 discards the op and clears the carry flag
    @(negedge clk);
    in_valid = 1'b1; op = 2'b00; a = 32'hFFFF_FFFF; b = 32'h0000_0001;
    @(posedge clk); #1;             // accept edge, chunk 0 next
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;           // after these, chunk 2 is in progress
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst.out_valid", out_valid, 1'b0);
    check("midrst.sum",       sum,       32'h0);
    check("midrst.in_ready",  in_ready,  1'b1);
    check("midrst.cout",      cout,      1'b0);
    $display("[TB] reset applied mid-operation");
    rst_n = 1'b1;
    do_op("adc_after_rst", 2'b10, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
